zimbo_mem_resp: RTL and testbench
=================================

Name: zimbo_mem_resp

Overview:
Memory responder for the Zimbo 16-bit core: the slave end of the core's memory port. It accepts byte-addressed word requests (instruction fetch or data load/store) and applies a programmable number of wait states. It services them from an internal word RAM and returns read data (rmdata) with a single-cycle ready pulse. The core's datapath drives addrm/wmdata; this block produces rmdata.

Parameters:
AW, 8, word-address width; RAM depth = 2**AW 16-bit words (byte address range 0 .. 2**(AW+1)-1)
WAITS, 2, wait-state cycles inserted between request capture and response (0..15)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req  input  1  access request; held high by requester until ready
we  input  1  1 = write, 0 = read; sampled with req
addrm  input  16  byte address; bit 0 must be 0 (word aligned)
wmdata  input  16  write data; sampled with req
rmdata  output  16  read data, valid in ready cycle, held until next read completes
ready  output  1  one-cycle completion pulse
err  output  1  error qualifier, valid only with ready (misaligned or out-of-range)
busy  output  1  high from request capture until the ready cycle inclusive

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, wait counter=0, rmdata=16'h0000, ready=0, err=0, busy=0; latched request registers cleared. RAM contents are NOT reset. Completed writes persist; an in-flight write is aborted and not committed.
- FSM states: IDLE, WAIT, RESP.
- IDLE: on a rising edge with req=1, latch addrm, we, wmdata. Set busy=1.
  - If WAITS>0: go to WAIT with counter=WAITS-1.
  - If WAITS=0: go directly to RESP.
  - With req=0: stay in IDLE.
- WAIT: counter decrements each cycle. At counter=0 go to RESP. req/we/addrm/wmdata changes are ignored (request already latched).
- RESP (one cycle): ready=1, busy=1; next state IDLE unconditionally.
  - Valid access (latched addr bit0=0 and addr[15:1] < 2**AW):
    - Write: RAM[addr[AW:1]] <= wdata at the end of the RESP cycle; err=0; rmdata unchanged.
    - Read: rmdata = RAM[addr[AW:1]] during the RESP cycle; err=0.
  - Misaligned (bit0=1) or out of range (any of addr[15:AW+1] nonzero): err=1, no RAM write; a read drives rmdata=16'h0000.
- Latency: the request is captured at edge k; ready is high in the cycle following edge k+WAITS+1. Total access time is WAITS+2 cycles including the capture cycle.
- Back-to-back: the cycle after RESP is IDLE and may capture a new req (one-cycle bubble minimum between ready pulses). A requester holding req high after ready starts a second, identical access (by protocol, the requester drops req in the ready cycle).
- req dropping during WAIT does not cancel the access; it completes and pulses ready.
- Read-after-write to the same address returns the new data (the write commits before the next capture).
- WAITS counter width is 4 bits; WAITS values above 15 are illegal (flagged by an elaboration check).
- Output timing: ready, err, busy, and rmdata are registered outputs, with no combinational path from inputs.

Test Plan:
- Reset: assert rst_n=0 mid-WAIT of a write of 16'hBEEF to 16'h0020 -> ready/busy/err/rmdata=0 immediately. After release, a read of 16'h0020 returns the prior contents, not 16'hBEEF.
- Basic write/read (WAITS=2): write 16'h1234 at 16'h0010 -> ready high exactly 3 edges after capture, err=0. Then read 16'h0010 -> rmdata=16'h1234 in the ready cycle and held afterwards.
- Misaligned/out-of-range (AW=8): read 16'h0011 -> ready with err=1, rmdata=16'h0000. Write 16'h0200 -> err=1, and RAM word 0 is unchanged.
- Zero wait (WAITS=0): read 16'h0000 -> ready in the cycle after capture. Continuous req pulsing -> ready every 2nd cycle, never consecutive.
- req dropped during WAIT (WAITS=4): read at 16'h00FE; drop req after 1 cycle -> ready still pulses once, 5 edges after capture, with correct data.
- Boundary: write 16'hA5A5 at 16'h01FE (last word) -> err=0. Read it back -> 16'hA5A5. Word 0 is unaffected (no wrap-around).

Source files
------------

// File: rtl/zimbo_mem_resp.sv
// Memory responder for the Zimbo 16-bit core: word RAM behind a req/ready port.
// Latency: capture edge k, ready high in the cycle after edge k+WAITS+1.
// Backpressure: none; the requester holds req until ready, and busy covers capture through ready.
module zimbo_mem_resp #(
    parameter int unsigned AW    = 8,
    parameter int unsigned WAITS = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [15:0] addrm,
    input  logic [15:0] wmdata,
    output logic [15:0] rmdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    // Counter is loaded with WAITS-1 so the WAIT state lasts exactly WAITS cycles.
    localparam logic [3:0] WAIT_INIT = (WAITS == 0) ? 4'd0 : 4'(WAITS - 1);

    // The wait counter is only 4 bits wide, so larger settings cannot be honoured.
    generate
        if (WAITS > 15) begin : g_bad_waits
            $error("zimbo_mem_resp: WAITS must be in 0..15");
        end
    endgenerate

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [15:0] wdata_q, wdata_d;

    logic [15:0] rmdata_q, rmdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic [15:0] mem [DEPTH];

    logic        in_resp;
    logic        acc_ok;
    logic        mem_wr;
    logic [AW-1:0] word_idx;

    // Decode of the latched request: aligned and inside the RAM, no wrap-around.
    always_comb begin
        in_resp  = (state_q == S_RESP);
        acc_ok   = !addr_q[0] && ((addr_q >> (AW + 1)) == 16'd0);
        word_idx = addr_q[AW:1];
        mem_wr   = in_resp && we_q && acc_ok;
    end

    // Request sequencing: capture in IDLE, count wait states, single RESP cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    addr_d  = addrm;
                    we_d    = we;
                    wdata_d = wmdata;
                    if (WAITS == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            S_WAIT: begin
                // Port inputs are ignored here; the access was latched at capture.
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered response outputs; rmdata only moves when a read completes.
    always_comb begin
        ready_d  = in_resp;
        err_d    = in_resp && !acc_ok;
        busy_d   = (state_q != S_IDLE) || req;
        rmdata_d = rmdata_q;
        if (in_resp && !we_q) begin
            rmdata_d = acc_ok ? mem[word_idx] : 16'h0000;
        end
    end

    // Control and output state, cleared asynchronously so an in-flight write is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 16'h0000;
            we_q     <= 1'b0;
            wdata_q  <= 16'h0000;
            rmdata_q <= 16'h0000;
            ready_q  <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rmdata_q <= rmdata_d;
            ready_q  <= ready_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
        end
    end

    // RAM array keeps its contents across reset; writes commit at the end of RESP.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[word_idx] <= wdata_q;
        end
    end

    assign rmdata = rmdata_q;
    assign ready  = ready_q;
    assign err    = err_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_zimbo_mem_resp.sv
// Directed bench for zimbo_mem_resp with three instances (WAITS = 2, 0, 4).
// Expected responses are queued when a request is driven and popped on ready.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_zimbo_mem_resp;

    typedef struct {
        logic [15:0] data;
        logic        err;
        logic        rd;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        req    [3];
    logic        we     [3];
    logic [15:0] addrm  [3];
    logic [15:0] wmdata [3];
    logic [15:0] rmdata [3];
    logic        ready  [3];
    logic        err    [3];
    logic        busy   [3];

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    zimbo_mem_resp #(.AW(8), .WAITS(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .req(req[0]), .we(we[0]), .addrm(addrm[0]),
        .wmdata(wmdata[0]), .rmdata(rmdata[0]), .ready(ready[0]), .err(err[0]), .busy(busy[0])
    );
    zimbo_mem_resp #(.AW(8), .WAITS(0)) u_w0 (
        .clk(clk), .rst_n(rst_n), .req(req[1]), .we(we[1]), .addrm(addrm[1]),
        .wmdata(wmdata[1]), .rmdata(rmdata[1]), .ready(ready[1]), .err(err[1]), .busy(busy[1])
    );
    zimbo_mem_resp #(.AW(8), .WAITS(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .req(req[2]), .we(we[2]), .addrm(addrm[2]),
        .wmdata(wmdata[2]), .rmdata(rmdata[2]), .ready(ready[2]), .err(err[2]), .busy(busy[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int waits_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 0 : 4);
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // One complete access on instance d; drop_after>0 releases req (and garbles
    // the port) that many cycles after capture.
    task automatic access(input int d, input logic w, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] ed,
                          input logic ee, input int drop_after, input string tag);
        exp_t e;
        int   n;
        bit   got;
        @(posedge clk); #1;
        req[d] = 1'b1; we[d] = w; addrm[d] = a; wmdata[d] = wd;
        e.data = ed; e.err = ee; e.rd = !w;
        sb.push_back(e);
        @(posedge clk); #1;
        check({tag, "/busy_cap"}, 16'(busy[d]), 16'h1);
        n = 0;
        got = 0;
        while (!got && n < 40) begin
            @(posedge clk); #1;
            n++;
            if (n == drop_after) begin
                req[d] = 1'b0; we[d] = 1'b1; addrm[d] = 16'h0011; wmdata[d] = 16'hDEAD;
            end
            if (ready[d]) got = 1;
        end
        req[d] = 1'b0;
        check({tag, "/latency"}, 16'(n), 16'(waits_of(d) + 1));
        e = sb.pop_front();
        if (got) begin
            check({tag, "/err"}, 16'(err[d]), 16'(e.err));
            check({tag, "/busy_rdy"}, 16'(busy[d]), 16'h1);
            if (e.rd) check({tag, "/rmdata"}, rmdata[d], e.data);
        end
        @(posedge clk); #1;
        check({tag, "/ready_pulse"}, 16'(ready[d]), 16'h0);
        check({tag, "/busy_done"}, 16'(busy[d]), 16'h0);
        if (e.rd) check({tag, "/rmdata_hold"}, rmdata[d], e.data);
    endtask

    initial begin
        int readies;
        int consec;
        logic prev;

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; we[i] = 1'b0; addrm[i] = 16'h0; wmdata[i] = 16'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst/ready", 16'(ready[0]), 16'h0);
        check("rst/busy", 16'(busy[0]), 16'h0);
        check("rst/err", 16'(err[0]), 16'h0);
        check("rst/rmdata", rmdata[0], 16'h0000);
        check("rst/busy_w0", 16'(busy[1]), 16'h0);
        rst_n = 1'b1;

        // Reset in the middle of a write: outputs clear, the write never lands.
        access(0, 1'b1, 16'h0020, 16'h5A5A, 16'h0000, 1'b0, 0, "w20");
        access(0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0, 0, "r20");
        @(posedge clk); #1;
        req[0] = 1'b1; we[0] = 1'b1; addrm[0] = 16'h0020; wmdata[0] = 16'hBEEF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        req[0] = 1'b0;
        #1;
        check("midrst/ready", 16'(ready[0]), 16'h0);
        check("midrst/busy", 16'(busy[0]), 16'h0);
        check("midrst/err", 16'(err[0]), 16'h0);
        check("midrst/rmdata", rmdata[0], 16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        access(0, 1'b0, 16'h0020, 16'h0000, 16'h5A5A, 1'b0, 0, "rst_r20");

        // Basic write then read with two wait states.
        access(0, 1'b1, 16'h0010, 16'h1234, 16'h0000, 1'b0, 0, "w10");
        access(0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 1'b0, 0, "r10");

        // Misaligned and out-of-range accesses.
        access(0, 1'b1, 16'h0000, 16'h0F0F, 16'h0000, 1'b0, 0, "w0");
        access(0, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 0, "rmis");
        access(0, 1'b1, 16'h0200, 16'hFFFF, 16'h0000, 1'b1, 0, "woor");
        access(0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 0, "r0a");

        // Last word of the RAM, and no wrap onto word 0.
        access(0, 1'b1, 16'h01FE, 16'hA5A5, 16'h0000, 1'b0, 0, "wlast");
        access(0, 1'b0, 16'h01FE, 16'h0000, 16'hA5A5, 1'b0, 0, "rlast");
        access(0, 1'b0, 16'h0000, 16'h0000, 16'h0F0F, 1'b0, 0, "r0b");

        // Zero wait states.
        access(1, 1'b1, 16'h0000, 16'hC3C3, 16'h0000, 1'b0, 0, "z_w0");
        access(1, 1'b0, 16'h0000, 16'h0000, 16'hC3C3, 1'b0, 0, "z_r0");

        // req held high continuously: ready on every second cycle only.
        @(posedge clk); #1;
        req[1] = 1'b1; we[1] = 1'b0; addrm[1] = 16'h0000;
        readies = 0;
        consec = 0;
        prev = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(posedge clk); #1;
            if (ready[1]) begin
                readies++;
                check("z_cont/rmdata", rmdata[1], 16'hC3C3);
                if (prev) consec++;
            end
            prev = ready[1];
        end
        req[1] = 1'b0;
        check("z_cont/readies", 16'(readies), 16'd5);
        check("z_cont/consecutive", 16'(consec), 16'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("z_cont/busy_done", 16'(busy[1]), 16'h0);

        // Four wait states with req released one cycle after capture.
        access(2, 1'b1, 16'h00FE, 16'h7E7E, 16'h0000, 1'b0, 0, "d_w");
        access(2, 1'b0, 16'h00FE, 16'h0000, 16'h7E7E, 1'b0, 1, "d_rdrop");
        access(2, 1'b0, 16'h00FE, 16'h0000, 16'h7E7E, 1'b0, 0, "d_rchk");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
